hcsr04_ranger: RTL
==================

// Module: hcsr04_ranger
// PURPOSE
//  Drives the HC-SR04 ultrasonic sensor: issues the trigger pulse and times the echo pulse.
//  Emits one cm_tick per centimetre of echo. This tick is the count input of the downstream BCD decade-counter chain.
//  Also latches a binary distance and reports timeouts.
//  Sits between the sensor pins and the decade counters / pitch logic of the theremin.
// PARAMETERS
//  TRIG_CYCLES     500        trigger high time in clocks (10 us @ 50 MHz)
//  CM_CYCLES       2900       echo clocks per centimetre (58 us @ 50 MHz)
//  TIMEOUT_CYCLES  1_500_000  max clocks in WAIT_ECHO or in MEASURE (30 ms)
//  PERIOD_CYCLES   3_000_000  min clocks between trigger rising edges (60 ms); > TRIG+2*TIMEOUT not required
//  DIST_W          9          width of dist_cm; saturates at 2**DIST_W-1
// PORTS
//  clock     in   1       system clock
//  reset     in   1       asynchronous, active-high
//  enable    in   1       1 = run continuous measurement cycles
//  echo      in   1       sensor echo pin, asynchronous to clock
//  trig      out  1       sensor trigger pin
//  cnt_clr   out  1       1-cycle pulse at echo rise; clears downstream decade counters
//  cm_tick   out  1       1-cycle pulse per completed centimetre of echo
//  dist_cm   out  DIST_W  last measured distance (cm), held until next result
//  valid     out  1       1-cycle pulse when dist_cm/timeout updated
//  timeout   out  1       1 = last cycle timed out; held until next result
//  busy      out  1       1 in any state except IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE; all counters 0; trig=cnt_clr=cm_tick=valid=timeout=busy=0; dist_cm=0.
//  echo: 2-flop synchroniser, then edge detect on synced value; pin-to-detect latency 3 clocks.
//  FSM states: IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF.
//   IDLE: enable=1 -> TRIG next cycle; the period counter is cleared.
//   TRIG: trig=1 for exactly TRIG_CYCLES clocks -> WAIT_ECHO.
//   WAIT_ECHO: on synced echo rise -> MEASURE, with cnt_clr=1 that cycle; cm_sub and run_dist cleared.
//     TIMEOUT_CYCLES elapsed with no rise -> HOLDOFF; timeout=1; dist_cm=all ones; valid=1.
//   MEASURE: cm_sub counts clocks. At cm_sub==CM_CYCLES-1: cm_sub<=0, cm_tick=1, run_dist+1.
//     Once run_dist==2**DIST_W-1: run_dist holds and cm_tick is suppressed.
//     On echo fall -> HOLDOFF; dist_cm<=run_dist (partial cm truncated); timeout=0; valid=1.
//     TIMEOUT_CYCLES in MEASURE without fall -> same as WAIT_ECHO timeout.
//     A tick and a fall in the same cycle: the tick counts before the latch.
//   HOLDOFF: waits until the period counter (started at TRIG entry) reaches PERIOD_CYCLES-1.
//     Then -> TRIG if enable=1, else IDLE. Echo edges are ignored here.
//  enable=0 mid-cycle: the current cycle completes through HOLDOFF, then IDLE. No truncated trigger.
//  Echo already high on TRIG exit: no rise is seen; timeout path applies.
//  Reset mid-operation: immediate return to the reset values above; trig drops asynchronously.
//  dist_cm, timeout, valid are registered outputs; trig, cnt_clr, cm_tick are registered.
// CONFIGURATION
//  HCSR04_GLITCH_FILTER_EN defined:
//   - The synced echo must hold a new level for 4 consecutive clocks before an edge is accepted.
//   - Detect latency becomes 7 clocks; pulses shorter than 4 clocks are ignored.
//  Not defined: no filter; any synced edge is accepted (3-clock latency).
// TESTING (sim params: TRIG=5, CM=10, TIMEOUT=200, PERIOD=400, DIST_W=4)
//  1. Reset -> trig=0, busy=0, valid=0, timeout=0, dist_cm=0, cnt_clr=0, cm_tick=0.
//  2. enable=1; echo high 35 clocks after trig -> trig high 5 clocks, one cnt_clr, 3 cm_tick, dist_cm=3, valid once.
//  3. No echo -> 200 clocks after trig falls: timeout=1, dist_cm=4'hF, valid pulse; next trig rises 400 clocks after the previous one.
//  4. Echo high 180 clocks -> 15 cm_tick only, dist_cm=15 (saturated), timeout=0.
//  5. Reset asserted mid-MEASURE -> all outputs at reset values at once; after release with enable=1, trig rises on the next clock.
//  6. 2-clock echo glitch in WAIT_ECHO:
//     with HCSR04_GLITCH_FILTER_EN -> ignored; a later 25-clock echo gives dist_cm=2.
//     without the macro -> dist_cm=0, valid pulse.

Source files
------------

// File: rtl/hcsr04_ranger.sv
// HC-SR04 ranger: fires the trigger pulse, times the echo in centimetre ticks, latches distance/timeout.
// Optional echo glitch filter enabled by defining HCSR04_GLITCH_FILTER_EN.
module hcsr04_ranger #(
   parameter int TRIG_CYCLES    = 500,
   parameter int CM_CYCLES      = 2900,
   parameter int TIMEOUT_CYCLES = 1_500_000,
   parameter int PERIOD_CYCLES  = 3_000_000,
   parameter int DIST_W         = 9
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              echo,
   output logic              trig,
   output logic              cnt_clr,
   output logic              cm_tick,
   output logic [DIST_W-1:0] dist_cm,
   output logic              valid,
   output logic              timeout,
   output logic              busy
);

   localparam int PH_MAX = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam int PER_W  = $clog2(PERIOD_CYCLES + 1);
   localparam int SUB_W  = $clog2(CM_CYCLES + 1);

   localparam logic [PH_W-1:0]   TRIG_LAST = PH_W'(TRIG_CYCLES - 1);
   localparam logic [PH_W-1:0]   TMO_LAST  = PH_W'(TIMEOUT_CYCLES - 1);
   localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
   localparam logic [SUB_W-1:0]  CM_LAST   = SUB_W'(CM_CYCLES - 1);
   localparam logic [DIST_W-1:0] DIST_MAX  = '1;

   typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF} state_t;

   state_t            state_reg, state_next;
   logic [PH_W-1:0]   phase_reg, phase_next;
   logic [PER_W-1:0]  period_reg, period_next;
   logic [SUB_W-1:0]  cm_sub_reg, cm_sub_next;
   logic [DIST_W-1:0] run_dist_reg, run_dist_next;
   logic [DIST_W-1:0] dist_reg, dist_next;
   logic              valid_reg, valid_next;
   logic              timeout_reg, timeout_next;
   logic              cnt_clr_reg, cnt_clr_next;
   logic              cm_tick_reg, cm_tick_next;
   logic              trig_reg, busy_reg;

   logic echo_s1_reg, echo_s2_reg, echo_prev_reg, echo_lvl, echo_rise, echo_fall;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         echo_s1_reg <= 1'b0;
         echo_s2_reg <= 1'b0;
      end else begin
         echo_s1_reg <= echo;
         echo_s2_reg <= echo_s1_reg;
      end
   end

`ifdef HCSR04_GLITCH_FILTER_EN
   // A new level is adopted only after the synced echo has differed from it for 4 clocks.
   logic       echo_flt_reg;
   logic [1:0] flt_cnt_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         echo_flt_reg <= 1'b0;
         flt_cnt_reg  <= 2'd0;
      end else if (echo_s2_reg == echo_flt_reg) begin
         flt_cnt_reg <= 2'd0;
      end else if (flt_cnt_reg == 2'd3) begin
         echo_flt_reg <= echo_s2_reg;
         flt_cnt_reg  <= 2'd0;
      end else begin
         flt_cnt_reg <= flt_cnt_reg + 2'd1;
      end
   end

   assign echo_lvl = echo_flt_reg;
`else
   assign echo_lvl = echo_s2_reg;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) echo_prev_reg <= 1'b0;
      else       echo_prev_reg <= echo_lvl;
   end

   assign echo_rise = echo_lvl & ~echo_prev_reg;
   assign echo_fall = ~echo_lvl & echo_prev_reg;

   always_comb begin
      state_next    = state_reg;
      phase_next    = phase_reg;
      period_next   = (period_reg == PER_LAST) ? period_reg : period_reg + 1'b1;
      cm_sub_next   = cm_sub_reg;
      run_dist_next = run_dist_reg;
      dist_next     = dist_reg;
      timeout_next  = timeout_reg;
      valid_next    = 1'b0;
      cnt_clr_next  = 1'b0;
      cm_tick_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            period_next = '0;
            if (enable) begin
               state_next = TRIG;
               phase_next = '0;
            end
         end
         TRIG: begin
            if (phase_reg == TRIG_LAST) begin
               state_next = WAIT_ECHO;
               phase_next = '0;
            end else begin
               phase_next = phase_reg + 1'b1;
            end
         end
         WAIT_ECHO: begin
            if (echo_rise) begin
               state_next    = MEASURE;
               phase_next    = '0;
               cnt_clr_next  = 1'b1;
               cm_sub_next   = '0;
               run_dist_next = '0;
            end else if (phase_reg == TMO_LAST) begin
               state_next   = HOLDOFF;
               timeout_next = 1'b1;
               dist_next    = DIST_MAX;
               valid_next   = 1'b1;
            end else begin
               phase_next = phase_reg + 1'b1;
            end
         end
         MEASURE: begin
            // The tick is resolved first so a coincident fall latches the incremented distance.
            if (cm_sub_reg == CM_LAST) begin
               cm_sub_next = '0;
               if (run_dist_reg != DIST_MAX) begin
                  run_dist_next = run_dist_reg + 1'b1;
                  cm_tick_next  = 1'b1;
               end
            end else begin
               cm_sub_next = cm_sub_reg + 1'b1;
            end
            if (echo_fall) begin
               state_next   = HOLDOFF;
               dist_next    = run_dist_next;
               timeout_next = 1'b0;
               valid_next   = 1'b1;
            end else if (phase_reg == TMO_LAST) begin
               state_next   = HOLDOFF;
               timeout_next = 1'b1;
               dist_next    = DIST_MAX;
               valid_next   = 1'b1;
            end else begin
               phase_next = phase_reg + 1'b1;
            end
         end
         HOLDOFF: begin
            if (period_reg == PER_LAST) begin
               state_next  = enable ? TRIG : IDLE;
               phase_next  = '0;
               period_next = '0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         phase_reg    <= '0;
         period_reg   <= '0;
         cm_sub_reg   <= '0;
         run_dist_reg <= '0;
         dist_reg     <= '0;
         valid_reg    <= 1'b0;
         timeout_reg  <= 1'b0;
         cnt_clr_reg  <= 1'b0;
         cm_tick_reg  <= 1'b0;
         trig_reg     <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         phase_reg    <= phase_next;
         period_reg   <= period_next;
         cm_sub_reg   <= cm_sub_next;
         run_dist_reg <= run_dist_next;
         dist_reg     <= dist_next;
         valid_reg    <= valid_next;
         timeout_reg  <= timeout_next;
         cnt_clr_reg  <= cnt_clr_next;
         cm_tick_reg  <= cm_tick_next;
         trig_reg     <= (state_next == TRIG);
         busy_reg     <= (state_next != IDLE);
      end
   end

   assign trig    = trig_reg;
   assign cnt_clr = cnt_clr_reg;
   assign cm_tick = cm_tick_reg;
   assign dist_cm = dist_reg;
   assign valid   = valid_reg;
   assign timeout = timeout_reg;
   assign busy    = busy_reg;

endmodule
